// File: rtl/gf_inv_1291.sv
// ============================================================================
// Module   : gf_inv_1291
// Purpose  : GF(1291) inverse via Fermat (a^1289) using one shared multiplier
//            and a Barrett reducer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gf_inv_1291 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] din_a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] dout_inv,
  output logic        dout_zero
);

  localparam logic [10:0] c_MODULUS = 11'd1291;
  localparam logic [11:0] c_MOD12   = 12'd1291;
  localparam logic [21:0] c_MU      = 22'd3248;
  localparam logic [10:0] c_EXP     = 11'b10100001001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SQR  = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic [10:0] r_a;
  logic [10:0] r_acc;
  logic [3:0]  r_idx;

  logic [10:0] w_din_red;
  logic [10:0] w_opb;
  logic [21:0] w_prod;
  logic [10:0] w_q;
  logic [10:0] w_t;
  logic [11:0] w_tp;
  logic [11:0] w_r0;
  logic [11:0] w_r1;
  logic [11:0] w_r2;
  logic [10:0] w_red;

  assign w_din_red = (din_a >= c_MODULUS) ? (din_a - c_MODULUS) : din_a;

  // Squaring reuses acc as the second operand; MUL pulls in the stored base.
  assign w_opb  = (r_state == S_MUL) ? r_a : r_acc;
  assign w_prod = {11'd0, r_acc} * {11'd0, w_opb};

  // Barrett: quotient estimate is at most 2 short, so r < 3*1291 fits 12 bits
  // and the subtraction can be done modulo 4096.
  assign w_q  = w_prod[21:11];
  assign w_t  = 11'(({11'd0, w_q} * c_MU) >> 11);
  assign w_tp = {1'b0, w_t} * c_MOD12;
  assign w_r0 = w_prod[11:0] - w_tp;
  assign w_r1 = (w_r0 >= c_MOD12) ? (w_r0 - c_MOD12) : w_r0;
  assign w_r2 = (w_r1 >= c_MOD12) ? (w_r1 - c_MOD12) : w_r1;
  assign w_red = w_r2[10:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_a       <= 11'd0;
      r_acc     <= 11'd0;
      r_idx     <= 4'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      dout_inv  <= 11'd0;
      dout_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= w_din_red;
            r_acc    <= w_din_red;
            r_idx    <= 4'd9;
            in_ready <= 1'b0;
            r_state  <= S_SQR;
          end
        end
        S_SQR: begin
          r_acc <= w_red;
          if (c_EXP[r_idx]) begin
            r_state <= S_MUL;
          end else if (r_idx == 4'd0) begin
            out_valid <= 1'b1;
            dout_inv  <= w_red;
            dout_zero <= (r_a == 11'd0);
            r_state   <= S_DONE;
          end else begin
            r_idx <= r_idx - 4'd1;
          end
        end
        S_MUL: begin
          r_acc <= w_red;
          if (r_idx == 4'd0) begin
            out_valid <= 1'b1;
            dout_inv  <= w_red;
            dout_zero <= (r_a == 11'd0);
            r_state   <= S_DONE;
          end else begin
            r_idx   <= r_idx - 4'd1;
            r_state <= S_SQR;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gf_inv_1291.sv
// ============================================================================
// Module   : tb_gf_inv_1291
// Purpose  : Self-checking bench for gf_inv_1291 against a modular-power model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gf_inv_1291;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] din_a = 11'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [10:0] dout_inv;
  logic        dout_zero;

  int checks = 0;
  int errors = 0;

  gf_inv_1291 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din_a    (din_a),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout_inv (dout_inv),
    .dout_zero(dout_zero)
  );

  always #5 clk = ~clk;

  // Reference: right-to-left modular exponentiation of the reduced operand.
  function automatic int inv_model(input int x);
    longint r, b, res;
    int e;
    r = x % 1291;
    if (r == 0) return 0;
    res = 1; b = r; e = 1289;
    while (e > 0) begin
      if (e & 1) res = (res * b) % 1291;
      b = (b * b) % 1291;
      e = e >> 1;
    end
    return int'(res);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic accept_op(input logic [10:0] v);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    check("accept_ready", in_ready, 1);
    in_valid = 1'b1; din_a = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_in_ready", in_ready, 0);
  endtask

  task automatic wait_result(input logic [10:0] v);
    int lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    check("latency", lat, 13);
    check("dout_inv", dout_inv, inv_model(int'(v)));
    check("dout_zero", dout_zero, (int'(v) % 1291 == 0) ? 1 : 0);
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  int          ops [3];
  int          acc_t [3];
  int          sent, got, stale;
  logic        will_acc, will_out;
  logic [10:0] cur, held, v;

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_dout_inv", dout_inv, 0);
    check("rst_dout_zero", dout_zero, 0);

    // Identity operand
    accept_op(11'd1); wait_result(11'd1); release_out();

    // Back-to-back with in_valid and out_ready held high
    ops[0] = 2; ops[1] = 3; ops[2] = 1290;
    sent = 0; got = 0;
    in_valid = 1'b1; din_a = 11'(ops[0]); out_ready = 1'b1;
    for (int c = 0; c < 120 && got < 3; c++) begin
      will_acc = in_valid && in_ready;
      will_out = out_valid && out_ready;
      cur = dout_inv;
      @(posedge clk); #1;
      if (will_acc) begin
        if (sent < 3) acc_t[sent] = c;
        sent++;
        if (sent < 3) din_a = 11'(ops[sent]); else in_valid = 1'b0;
      end
      if (will_out) begin
        if (got < 3) check("b2b_result", cur, inv_model(ops[got]));
        got++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_accepts", sent, 3);
    check("b2b_results", got, 3);
    check("b2b_gap1", acc_t[1] - acc_t[0], 15);
    check("b2b_gap2", acc_t[2] - acc_t[1], 15);
    check("b2b_646", inv_model(ops[0]), 646);

    // Zero and out-of-range operands
    accept_op(11'd0);    wait_result(11'd0);    release_out();
    accept_op(11'd1293); wait_result(11'd1293); release_out();
    accept_op(11'd2047); wait_result(11'd2047);
    check("inv_2047_product", (int'(dout_inv) * 756) % 1291, 1);
    release_out();

    // Back-pressure: result held, new operand refused
    accept_op(11'd7); wait_result(11'd7);
    held = dout_inv;
    in_valid = 1'b1; din_a = 11'd9;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_data", dout_inv, held);
      check("hold_no_accept", in_ready, 0);
    end
    in_valid = 1'b0;
    release_out();

    // Asynchronous reset mid-computation
    accept_op(11'd5);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_dout_inv", dout_inv, 0);
    check("arst_dout_zero", dout_zero, 0);
    check("arst_in_ready", in_ready, 1);
    @(posedge clk); #1 rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) stale++;
    end
    check("no_stale_result", stale, 0);
    accept_op(11'd2); wait_result(11'd2); release_out();

    // Random operands over the full input range
    for (int i = 0; i < 40; i++) begin
      v = 11'($urandom_range(0, 2047));
      accept_op(v); wait_result(v); release_out();
    end

    // Exhaustive sweep of nonzero field elements
    for (int x = 1; x <= 1290; x++) begin
      accept_op(11'(x)); wait_result(11'(x));
      check("sweep_product", (int'(dout_inv) * x) % 1291, 1);
      release_out();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gf_inv_1291.md
# gf_inv_1291

Sequential multiplicative-inverse unit for GF(1291). It computes a^(1291−2) = a^1289 mod 1291 (Fermat) by left-to-right square-and-multiply. A single shared 11×11 multiplier feeds an internal Barrett reducer for modulus 1291. The block is the consumer-side counterpart of the GF(1291) product/reduce path: it takes field elements in and returns their inverses, so division can be built from it. Valid/ready on both sides.

## Interface
- None. Modulus 1291, Barrett constant mu = 3248, shift k = 11 and exponent 1289 are fixed; the generator emits one module per modulus.

- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  din_a is valid
- in_ready  out  1  block can accept an operand (high only in IDLE)
- din_a  in  11  operand; 0..2047 accepted, values ≥1291 are reduced once at acceptance
- out_valid  out  1  dout_inv/dout_zero valid
- out_ready  in  1  downstream accepts result
- dout_inv  out  11  a^−1 mod 1291, range 0..1290
- dout_zero  out  1  reduced operand was 0 (no inverse exists); dout_inv = 0

## Operation
- Reduction function red(x) for x < 1291² (< 2^21):
  - q = x >> 11.
  - q_hat = q·3248, held at 22 bits (≤ 1023·3248 < 2^22). No 21-bit wrap is permitted.
  - t = q_hat >> 11; r = x − t·1291.
  - Two conditional subtractions of 1291 follow.
  - The result must equal x mod 1291 exactly for every x < 1291².
- Exponent 1289 = 0b10100001001. The MSB is consumed at load; bits 9..0 are processed in order.
- States:
  - IDLE: in_ready = 1. On in_valid:
    - a ← din_a ≥ 1291 ? din_a − 1291 : din_a
    - acc ← the same reduced value
    - idx ← 9
    - → SQR
  - SQR: acc ← red(acc·acc).
    - E[idx] = 1 → MUL.
    - Otherwise, idx = 0 → DONE.
    - Otherwise idx ← idx−1 and stay in SQR.
  - MUL: acc ← red(acc·a).
    - idx = 0 → DONE.
    - Otherwise idx ← idx−1 → SQR.
  - DONE: out_valid = 1, dout_inv = acc, dout_zero = (a == 0).
    - On out_ready → IDLE.
- Operation count is data-independent: 10 squarings plus 3 multiplies (bits 8, 3, 0) = 13 operations.
- Zero operand: the computation runs normally, producing acc = 0, and dout_zero = 1. There is no early exit, so latency stays constant.
- in_valid while not in IDLE is ignored (in_ready = 0). The operand is not captured.
- In DONE, dout_inv and dout_zero are held stable until the out_ready handshake.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, dout_inv = 0, dout_zero = 0, acc = 0, a = 0, idx = 0.
- Reset mid-operation (any state) aborts immediately and asynchronously. Outputs take their reset values, and no result is emitted after release.
- Latency:
  - Accept at rising edge N (in_valid & in_ready).
  - The SQR/MUL operations complete at edges N+1..N+13.
  - out_valid rises after edge N+13, i.e. 13 cycles.
- Handshake:
  - The result transfers at the first edge with out_valid & out_ready.
  - in_ready rises after that edge.
  - The next accept is possible one cycle later.
  - Minimum initiation interval is 15 cycles with out_ready held high.
- The multiply and reduce of one operation complete combinationally within one cycle. Registers: acc, a, idx, state and the output registers.
- A simultaneous in_valid during the DONE-to-IDLE edge is not accepted; in_ready is registered from state.

## Test plan
- Reset then din_a = 1, in_valid pulse → in_ready drops; out_valid exactly 13 cycles after accept; dout_inv = 1, dout_zero = 0.
- Back-to-back operands 2, 3, 1290 with out_ready = 1 → results 646, 861, 1290 in order. Each accept is 15 cycles apart, and in_valid held during busy captures nothing extra.
- din_a = 0 → dout_inv = 0, dout_zero = 1, still 13-cycle latency. din_a = 1293 → reduced to 2 → dout_inv = 646. din_a = 2047 → reduced to 756; check result·756 mod 1291 = 1.
- out_ready held low 20 cycles in DONE → out_valid and dout_inv stable; no new operand is accepted. Raise out_ready → in_ready high the next cycle.
- Assert rst at cycle 6 of a computation → out_valid, dout_inv and dout_zero are 0 immediately. After release, no stale result appears, and a fresh operand 2 yields 646.
- Exhaustive sweep of din_a = 1..1290 → dout_inv·din_a mod 1291 = 1 for all. Separately, exhaustive check of red(x) = x mod 1291 for all x < 1291².
